// File: rtl/kt_uart_pkg.sv
// Shared constants and state types for the KnightsTour UART command link.
package kt_uart_pkg;

  localparam int BAUD_DIV_DEF     = 2604;
  localparam int TIMEOUT_CLKS_DEF = 65536;

  // Response byte the command processor returns on success.
  localparam logic [7:0] ACK = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_t;

  typedef enum logic {
    HIGH = 1'b0,
    LOW  = 1'b1
  } asm_state_t;

  // Data bits plus stop bit; the start bit is driven directly when the frame loads.
  function automatic logic [8:0] tx_frame_load(input logic [7:0] data);
    return {1'b1, data};
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: RX synchroniser, mid-bit sampling and shift register.
// rx_rdy pulses for a good byte; rx_frm_err pulses when the stop bit samples low.
module uart_rx_byte
  import kt_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       rx_frm_err,
  output logic       rx_start_det,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

  rx_state_t        state_r, state_nxt_s;
  logic             rx_meta_r, rx_sync_r, rx_prev_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [3:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic             rx_rdy_r, frm_err_r, start_det_r;
  logic             cnt_clr_s, shift_en_s, good_s, bad_s, start_s;
  logic             fall_s, half_s, full_s;

  assign fall_s = rx_prev_r & ~rx_sync_r;
  assign half_s = (baud_cnt_r == HALF_M1);
  assign full_s = (baud_cnt_r == FULL_M1);

  // Two-flop synchroniser plus edge-detect history, preset to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= RX_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state and sampling strobes for the receive frame.
  always_comb begin
    state_nxt_s = state_r;
    cnt_clr_s   = 1'b0;
    shift_en_s  = 1'b0;
    good_s      = 1'b0;
    bad_s       = 1'b0;
    start_s     = 1'b0;
    case (state_r)
      RX_IDLE: begin
        if (fall_s) begin
          start_s     = 1'b1;
          cnt_clr_s   = 1'b1;
          state_nxt_s = RX_START;
        end else begin
          state_nxt_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (half_s) begin
          cnt_clr_s = 1'b1;
          // A start bit that is high again at mid-bit was a glitch.
          if (rx_sync_r) state_nxt_s = RX_IDLE;
          else           state_nxt_s = RX_DATA;
        end else begin
          state_nxt_s = RX_START;
        end
      end
      RX_DATA: begin
        if (full_s) begin
          cnt_clr_s  = 1'b1;
          shift_en_s = 1'b1;
          if (bit_cnt_r == 4'd7) state_nxt_s = RX_STOP;
          else                   state_nxt_s = RX_DATA;
        end else begin
          state_nxt_s = RX_DATA;
        end
      end
      RX_STOP: begin
        if (full_s) begin
          state_nxt_s = RX_IDLE;
          if (rx_sync_r) good_s = 1'b1;
          else           bad_s  = 1'b1;
        end else begin
          state_nxt_s = RX_STOP;
        end
      end
      default: state_nxt_s = RX_IDLE;
    endcase
  end

  // Baud counter, bit counter and LSB-first shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_r <= '0;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'h00;
    end else begin
      if (cnt_clr_s || state_r == RX_IDLE) baud_cnt_r <= '0;
      else                                 baud_cnt_r <= baud_cnt_r + CNT_W'(1);
      if (state_r == RX_START) bit_cnt_r <= 4'd0;
      else if (shift_en_s)     bit_cnt_r <= bit_cnt_r + 4'd1;
      else                     bit_cnt_r <= bit_cnt_r;
      if (shift_en_s) shift_r <= {rx_sync_r, shift_r[7:1]};
      else            shift_r <= shift_r;
    end
  end

  // Registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_rdy_r    <= 1'b0;
      frm_err_r   <= 1'b0;
      start_det_r <= 1'b0;
    end else begin
      rx_rdy_r    <= good_s;
      frm_err_r   <= bad_s;
      start_det_r <= start_s;
    end
  end

  assign rx_data      = shift_r;
  assign rx_rdy       = rx_rdy_r;
  assign rx_frm_err   = frm_err_r;
  assign rx_start_det = start_det_r;
  assign rx_busy      = (state_r != RX_IDLE);

endmodule

// File: rtl/uart_cmd_wrapper.sv
// DUT-side end of the RemoteComm link: assembles two received bytes into a
// 16-bit command and serialises the 8-bit response, full duplex.
module uart_cmd_wrapper
  import kt_uart_pkg::*;
#(
  parameter int BAUD_DIV     = BAUD_DIV_DEF,
  parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        trmt,
  input  logic [7:0]  resp,
  output logic        tx_done
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CLKS);

  logic [7:0] rx_data_s;
  logic       rx_rdy_s, rx_frm_err_s, rx_start_det_s, rx_busy_s;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (RX),
    .rx_data      (rx_data_s),
    .rx_rdy       (rx_rdy_s),
    .rx_frm_err   (rx_frm_err_s),
    .rx_start_det (rx_start_det_s),
    .rx_busy      (rx_busy_s)
  );

  // ---------------- command assembly ----------------
  asm_state_t       asm_state_r, asm_nxt_s;
  logic [7:0]       hi_r;
  logic [15:0]      cmd_r;
  logic             cmd_rdy_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             store_hi_s, load_cmd_s, tmo_s;

  assign tmo_s = (tmo_cnt_r == TMO_LIM);

  // Assembly state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) asm_state_r <= HIGH;
    else        asm_state_r <= asm_nxt_s;
  end

  // High/low byte sequencing; a framing error or timeout abandons the pair.
  always_comb begin
    asm_nxt_s  = asm_state_r;
    store_hi_s = 1'b0;
    load_cmd_s = 1'b0;
    case (asm_state_r)
      HIGH: begin
        if (rx_rdy_s) begin
          store_hi_s = 1'b1;
          asm_nxt_s  = LOW;
        end else begin
          asm_nxt_s = HIGH;
        end
      end
      LOW: begin
        if (rx_frm_err_s) begin
          asm_nxt_s = HIGH;
        end else if (rx_rdy_s) begin
          load_cmd_s = 1'b1;
          asm_nxt_s  = HIGH;
        end else if (tmo_s) begin
          asm_nxt_s = HIGH;
        end else begin
          asm_nxt_s = LOW;
        end
      end
      default: asm_nxt_s = HIGH;
    endcase
  end

  // Inter-byte timeout: runs in LOW only while no low byte is being received.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                             tmo_cnt_r <= '0;
    else if (store_hi_s)                                    tmo_cnt_r <= '0;
    else if (asm_state_r == LOW && !rx_busy_s && !tmo_s)    tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    else                                                    tmo_cnt_r <= tmo_cnt_r;
  end

  // High-byte holding register, command register and ready flag (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r      <= 8'h00;
      cmd_r     <= 16'h0000;
      cmd_rdy_r <= 1'b0;
    end else begin
      if (store_hi_s) hi_r <= rx_data_s;
      else            hi_r <= hi_r;
      if (load_cmd_s) cmd_r <= {hi_r, rx_data_s};
      else            cmd_r <= cmd_r;
      if (load_cmd_s)                                                 cmd_rdy_r <= 1'b1;
      else if (clr_cmd_rdy || (rx_start_det_s && asm_state_r == HIGH)) cmd_rdy_r <= 1'b0;
      else                                                            cmd_rdy_r <= cmd_rdy_r;
    end
  end

  // ---------------- response transmitter ----------------
  tx_state_t        tx_state_r, tx_nxt_s;
  logic [CNT_W-1:0] tx_cnt_r;
  logic [3:0]       tx_bit_r;
  logic [8:0]       tx_sreg_r;
  logic             tx_r, tx_done_r;
  logic             tx_load_s, tx_step_s, tx_fin_s, tx_full_s;

  assign tx_full_s = (tx_cnt_r == FULL_M1);

  // Transmitter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state_r <= TX_IDLE;
    else        tx_state_r <= tx_nxt_s;
  end

  // Frame sequencing; trmt is only honoured while idle.
  always_comb begin
    tx_nxt_s  = tx_state_r;
    tx_load_s = 1'b0;
    tx_step_s = 1'b0;
    tx_fin_s  = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        if (trmt) begin
          tx_load_s = 1'b1;
          tx_nxt_s  = TX_SHIFT;
        end else begin
          tx_nxt_s = TX_IDLE;
        end
      end
      TX_SHIFT: begin
        if (tx_full_s) begin
          if (tx_bit_r == 4'd9) begin
            tx_fin_s = 1'b1;
            tx_nxt_s = TX_IDLE;
          end else begin
            tx_step_s = 1'b1;
            tx_nxt_s  = TX_SHIFT;
          end
        end else begin
          tx_nxt_s = TX_SHIFT;
        end
      end
      default: tx_nxt_s = TX_IDLE;
    endcase
  end

  // Bit timing, shift register, registered TX line and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_r  <= '0;
      tx_bit_r  <= 4'd0;
      tx_sreg_r <= 9'h1FF;
      tx_r      <= 1'b1;
      tx_done_r <= 1'b0;
    end else begin
      if (tx_load_s || tx_step_s || tx_state_r == TX_IDLE) tx_cnt_r <= '0;
      else                                                 tx_cnt_r <= tx_cnt_r + CNT_W'(1);
      if (tx_load_s)      tx_bit_r <= 4'd0;
      else if (tx_step_s) tx_bit_r <= tx_bit_r + 4'd1;
      else                tx_bit_r <= tx_bit_r;
      if (tx_load_s)      tx_sreg_r <= tx_frame_load(resp);
      else if (tx_step_s) tx_sreg_r <= {1'b1, tx_sreg_r[8:1]};
      else                tx_sreg_r <= tx_sreg_r;
      if (tx_load_s)      tx_r <= 1'b0;
      else if (tx_step_s) tx_r <= tx_sreg_r[0];
      else if (tx_fin_s)  tx_r <= 1'b1;
      else                tx_r <= tx_r;
      tx_done_r <= tx_fin_s;
    end
  end

  assign TX      = tx_r;
  assign tx_done = tx_done_r;
  assign cmd     = cmd_r;
  assign cmd_rdy = cmd_rdy_r;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper with a short baud divider and timeout.
`timescale 1ns/1ps
module tb_uart_cmd_wrapper;

  localparam int B   = 16;
  localparam int TMO = 512;

  logic        clk, rst_n, RX, TX, cmd_rdy, clr_cmd_rdy, trmt, tx_done;
  logic [15:0] cmd;
  logic [7:0]  resp;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int tx_low_cnt = 0;

  uart_cmd_wrapper #(.BAUD_DIV(B), .TIMEOUT_CLKS(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .trmt        (trmt),
    .resp        (resp),
    .tx_done     (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Observe tx_done pulses and TX low cycles away from the active edge.
  always @(negedge clk) begin
    if (tx_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (!TX) tx_low_cnt <= tx_low_cnt + 1;
  end

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp_cmd;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop_bit);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(B);
    end
    RX = stop_bit;
    tick(B);
    RX = 1'b1;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    tick(B);
    send_bits(b, stop_bit);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic capture_frame(output logic [9:0] bits);
    tick(B / 2);
    bits[0] = TX;
    for (int k = 1; k < 10; k++) begin
      tick(B);
      bits[k] = TX;
    end
  endtask

  logic [9:0] tx_exp;
  logic [9:0] got_bits;
  int         t0, base_done, base_low, n;
  logic       found;

  initial begin
    vecs[0] = '{hi: 8'h12, lo: 8'h34, exp_cmd: 16'h1234};
    vecs[1] = '{hi: 8'h00, lo: 8'h00, exp_cmd: 16'h0000};
    vecs[2] = '{hi: 8'hFF, lo: 8'hFF, exp_cmd: 16'hFFFF};
    vecs[3] = '{hi: 8'hA5, lo: 8'h5A, exp_cmd: 16'hA55A};

    rst_n = 1'b0; RX = 1'b1; trmt = 1'b0; clr_cmd_rdy = 1'b0; resp = 8'h00;
    tick(3);
    check("rst_tx", TX, 1);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_tx_done", tx_done, 0);
    rst_n = 1'b1;
    tick(2);

    // Test 1: basic pair, TX must stay idle.
    base_low = tx_low_cnt;
    send_byte(8'h47, 1'b1);
    check("t1_rdy_after_hi", cmd_rdy, 0);
    send_byte(8'hF2, 1'b1);
    check("t1_cmd_rdy", cmd_rdy, 1);
    check("t1_cmd", cmd, 16'h47F2);
    check("t1_tx_idle", tx_low_cnt - base_low, 0);

    // Test 2: next pair clears cmd_rdy at its first start bit.
    RX = 1'b0;
    tick(B / 2);
    check("t2_rdy_drop_at_start", cmd_rdy, 0);
    check("t2_cmd_held", cmd, 16'h47F2);
    tick(B - B / 2);
    send_bits(8'h4B, 1'b1);
    send_byte(8'hF1, 1'b1);
    check("t2_cmd_rdy", cmd_rdy, 1);
    check("t2_cmd", cmd, 16'h4BF1);
    pulse_clr();
    check("t2_clr_rdy", cmd_rdy, 0);
    check("t2_clr_cmd_held", cmd, 16'h4BF1);

    // Table-driven pairs.
    for (int i = 0; i < 4; i++) begin
      send_byte(vecs[i].hi, 1'b1);
      send_byte(vecs[i].lo, 1'b1);
      check($sformatf("vec%0d_rdy", i), cmd_rdy, 1);
      check($sformatf("vec%0d_cmd", i), cmd, vecs[i].exp_cmd);
      pulse_clr();
      check($sformatf("vec%0d_clr", i), cmd_rdy, 0);
    end

    // Test 3: A5 response frame with an ignored mid-frame trmt.
    tx_exp = 10'b1101001010;
    base_done = done_cnt;
    resp = 8'hA5; trmt = 1'b1;
    tick(1);
    trmt = 1'b0;
    t0 = cyc;
    tick(B / 2);
    check("tx_a5_bit0", TX, tx_exp[0]);
    for (int k = 1; k < 10; k++) begin
      if (k == 3) begin
        resp = 8'h00; trmt = 1'b1;
        tick(1);
        trmt = 1'b0;
        tick(B - 1);
      end else begin
        tick(B);
      end
      check($sformatf("tx_a5_bit%0d", k), TX, tx_exp[k]);
    end
    tick(B);
    check("tx_done_once", done_cnt - base_done, 1);
    check("tx_done_latency", done_cyc - t0, 10 * B);
    check("tx_idle_after", TX, 1);

    // Back-to-back trmt on the tx_done cycle.
    resp = 8'h3C; trmt = 1'b1;
    tick(1);
    trmt = 1'b0;
    n = 0; found = 1'b0;
    while (!found && n < 12 * B) begin
      tick(1);
      n++;
      if (tx_done) found = 1'b1;
    end
    check("b2b_done_seen", found, 1);
    resp = 8'hC3; trmt = 1'b1;
    tick(1);
    trmt = 1'b0;
    capture_frame(got_bits);
    check("b2b_frame", got_bits, 10'b1110000110);
    tick(B);

    // Test 4: lone high byte times out and is discarded.
    send_byte(8'h40, 1'b1);
    check("t4_no_rdy_lone", cmd_rdy, 0);
    tick(TMO + 10);
    check("t4_no_rdy_tmo", cmd_rdy, 0);
    send_byte(8'h40, 1'b1);
    send_byte(8'h02, 1'b1);
    check("t4_rdy", cmd_rdy, 1);
    check("t4_cmd", cmd, 16'h4002);

    // Test 5: framing error on the high byte.
    send_byte(8'h99, 1'b0);
    tick(2 * B);
    check("t5_no_rdy_bad", cmd_rdy, 0);
    check("t5_cmd_held", cmd, 16'h4002);
    send_byte(8'h43, 1'b1);
    send_byte(8'hF1, 1'b1);
    check("t5_rdy", cmd_rdy, 1);
    check("t5_cmd", cmd, 16'h43F1);

    // Test 6: async reset during RX and TX frames.
    resp = 8'h00; trmt = 1'b1; RX = 1'b0;
    tick(1);
    trmt = 1'b0;
    tick(B + B / 2);
    check("t6_tx_busy_pre", TX, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_tx", TX, 1);
    check("t6_rst_rdy", cmd_rdy, 0);
    check("t6_rst_cmd", cmd, 16'h0000);
    RX = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3 * B);
    check("t6_no_partial", cmd_rdy, 0);
    send_byte(8'h40, 1'b1);
    send_byte(8'h02, 1'b1);
    check("t6_rdy", cmd_rdy, 1);
    check("t6_cmd", cmd, 16'h4002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
